// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the source-clock reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STRETCH,
    ST_RUN
  } t_rst_seq_state;

  // Width of a counter that must reach max(a,b)-1; never narrower than one bit.
  function automatic int unsigned f_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/multi_stage_synchronizer.sv
// N-flop synchronizer with asynchronous active-low clear to zero.
module multi_stage_synchronizer #(
  parameter int unsigned par_stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [par_stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[par_stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[par_stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequences the source-clock domain reset: release bridge, MMCM lock settle,
// stretch, then run; re-enters reset on lock loss or software request.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned par_sync_stages = 2,
  parameter int unsigned par_lock_settle = 256,
  parameter int unsigned par_rst_stretch = 16
) (
  input  logic i_clk_mhz,
  input  logic i_rst_mhz,
  input  logic i_mmcm_locked,
  input  logic i_sw_rst_req,
  output logic o_rst_mhz,
  output logic o_rst_done,
  output logic o_locked_sync
);

  localparam int unsigned CW = f_cnt_width(par_lock_settle, par_rst_stretch);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(par_lock_settle - 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(par_rst_stretch - 1);

  logic           bridge;
  logic           locked_sync;
  t_rst_seq_state state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rst_q;
  logic           done_q, done_d;

  multi_stage_synchronizer #(.par_stages(par_sync_stages)) u_bridge (
    .clk_i  (i_clk_mhz),
    .rst_ni (i_rst_mhz),
    .d_i    (1'b1),
    .q_o    (bridge)
  );

  multi_stage_synchronizer #(.par_stages(par_sync_stages)) u_lock_sync (
    .clk_i  (i_clk_mhz),
    .rst_ni (i_rst_mhz),
    .d_i    (i_mmcm_locked),
    .q_o    (locked_sync)
  );

  // Lock loss is checked first in STRETCH/RUN so it outranks a software request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (bridge) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (!locked_sync) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STRETCH: begin
        if (!locked_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (i_sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (i_sw_rst_req) begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset output is registered from the next state so it changes on the transition edge.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz) begin
    if (!i_rst_mhz) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= (state_d != ST_RUN);
      done_q  <= done_d;
    end
  end

  assign o_rst_mhz     = rst_q;
  assign o_rst_done    = done_q;
  assign o_locked_sync = locked_sync;

endmodule
